// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: byte-addressed little-endian data memory, load extraction,
// write-back register, and branch/jr redirect with pipeline flush.
module mem_wb_stage #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_ans_Mem,
    input  logic [31:0] busB_Mem,
    input  logic [31:0] PC_Addr_Mem,
    input  logic [5:0]  OP_Mem,
    input  logic [4:0]  Reg_Target_Mem,
    input  logic        ZF_Mem,
    input  logic        OF_Mem,
    input  logic        Sign_Mem,
    input  logic        Branch_Mem,
    input  logic        MemToReg_Mem,
    input  logic        RegWr_Mem,
    input  logic        MemWr_Mem,
    input  logic        Jal_Mem,
    input  logic        Rtype_J_Mem,
    input  logic        Rtype_L_Mem,
    input  logic        WrByte_Mem,
    input  logic [1:0]  LoadByte_Mem,
    output logic [31:0] Wr_Data_Wb,
    output logic [4:0]  Reg_Target_Wb,
    output logic        RegWr_Wb,
    output logic        PC_Src,
    output logic [31:0] PC_Target,
    output logic        Flush
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [7:0]    lane_byte;
    logic [31:0]   load_data;
    logic [31:0]   wb_data_next;
    logic [4:0]    wb_target_next;
    logic          wb_we_next;
    logic          branch_taken;
    logic          redirect_jr;
    logic          unused_addr_bits;

    assign word_idx         = ALU_ans_Mem[AW+1:2];
    assign lane             = ALU_ans_Mem[1:0];
    assign unused_addr_bits = ^ALU_ans_Mem[31:AW+2];
    assign rd_word          = mem[word_idx];

    // Byte stores merge the new byte into the current word; word stores take busB whole.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word[8*gi +: 8] = !WrByte_Mem          ? busB_Mem[8*gi +: 8] :
                                        (lane == 2'(gi))     ? busB_Mem[7:0]       :
                                                               rd_word[8*gi +: 8];
        end
    endgenerate

    // Memory contents survive reset; only the write itself is blocked.
    always_ff @(posedge clk) begin
        if (!rst && MemWr_Mem) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_comb begin
        lane_byte = rd_word[7:0];
        case (lane)
            2'd0: lane_byte = rd_word[7:0];
            2'd1: lane_byte = rd_word[15:8];
            2'd2: lane_byte = rd_word[23:16];
            2'd3: lane_byte = rd_word[31:24];
            default: lane_byte = rd_word[7:0];
        endcase
    end

    always_comb begin
        load_data = rd_word;
        case (LoadByte_Mem)
            2'b01:   load_data = {{24{lane_byte[7]}}, lane_byte};
            2'b10:   load_data = {24'b0, lane_byte};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        wb_data_next = ALU_ans_Mem;
        if (Jal_Mem) begin
            wb_data_next = ALU_ans_Mem;
        end else if (MemToReg_Mem) begin
            wb_data_next = load_data;
        end else if (Rtype_L_Mem) begin
            wb_data_next = {31'b0, Sign_Mem ^ OF_Mem};
        end
    end

    // Overflow only cancels plain ALU results; r0 is never written.
    assign wb_target_next = Jal_Mem ? 5'd31 : Reg_Target_Mem;
    assign wb_we_next     = RegWr_Mem
                          && !(OF_Mem && !Jal_Mem && !MemToReg_Mem && !Rtype_L_Mem)
                          && (wb_target_next != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            Wr_Data_Wb    <= 32'b0;
            Reg_Target_Wb <= 5'b0;
            RegWr_Wb      <= 1'b0;
        end else begin
            Wr_Data_Wb    <= wb_data_next;
            Reg_Target_Wb <= wb_target_next;
            RegWr_Wb      <= wb_we_next;
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        if (Branch_Mem) begin
            case (OP_Mem)
                6'b000100: branch_taken = ZF_Mem;
                6'b000101: branch_taken = !ZF_Mem;
                6'b000110: branch_taken = ZF_Mem | Sign_Mem;
                6'b000111: branch_taken = !ZF_Mem & !Sign_Mem;
                default:   branch_taken = 1'b0;
            endcase
        end
    end

    assign redirect_jr = !rst && Rtype_J_Mem;
    assign PC_Src      = !rst && (Rtype_J_Mem || branch_taken);
    assign PC_Target   = redirect_jr ? ALU_ans_Mem : PC_Addr_Mem;
    assign Flush       = PC_Src;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stimulus pushes expected write-back results into a
// queue that a posedge monitor drains; redirect outputs are checked in the drive cycle.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_ans_Mem, busB_Mem, PC_Addr_Mem;
    logic [5:0]  OP_Mem;
    logic [4:0]  Reg_Target_Mem;
    logic        ZF_Mem, OF_Mem, Sign_Mem, Branch_Mem, MemToReg_Mem, RegWr_Mem;
    logic        MemWr_Mem, Jal_Mem, Rtype_J_Mem, Rtype_L_Mem, WrByte_Mem;
    logic [1:0]  LoadByte_Mem;
    logic [31:0] Wr_Data_Wb, PC_Target;
    logic [4:0]  Reg_Target_Wb;
    logic        RegWr_Wb, PC_Src, Flush;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [4:0]  tgt;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .ALU_ans_Mem(ALU_ans_Mem), .busB_Mem(busB_Mem), .PC_Addr_Mem(PC_Addr_Mem),
        .OP_Mem(OP_Mem), .Reg_Target_Mem(Reg_Target_Mem),
        .ZF_Mem(ZF_Mem), .OF_Mem(OF_Mem), .Sign_Mem(Sign_Mem), .Branch_Mem(Branch_Mem),
        .MemToReg_Mem(MemToReg_Mem), .RegWr_Mem(RegWr_Mem), .MemWr_Mem(MemWr_Mem),
        .Jal_Mem(Jal_Mem), .Rtype_J_Mem(Rtype_J_Mem), .Rtype_L_Mem(Rtype_L_Mem),
        .WrByte_Mem(WrByte_Mem), .LoadByte_Mem(LoadByte_Mem),
        .Wr_Data_Wb(Wr_Data_Wb), .Reg_Target_Wb(Reg_Target_Wb), .RegWr_Wb(RegWr_Wb),
        .PC_Src(PC_Src), .PC_Target(PC_Target), .Flush(Flush)
    );

    // Monitor: the stage produces one write-back result per edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (Wr_Data_Wb !== e.data || Reg_Target_Wb !== e.tgt || RegWr_Wb !== e.we) begin
                    bad++;
                    $display("FAIL %s wb: got data=%08h tgt=%0d we=%0b, want data=%08h tgt=%0d we=%0b",
                             e.name, Wr_Data_Wb, Reg_Target_Wb, RegWr_Wb, e.data, e.tgt, e.we);
                end else begin
                    $display("ok   %s wb: data=%08h tgt=%0d we=%0b", e.name, Wr_Data_Wb, Reg_Target_Wb, RegWr_Wb);
                end
            end
        end
    end

    task automatic clr();
        rst = 1'b0; ALU_ans_Mem = 32'h0; busB_Mem = 32'h0; PC_Addr_Mem = 32'h100;
        OP_Mem = 6'h0; Reg_Target_Mem = 5'd0; ZF_Mem = 1'b0; OF_Mem = 1'b0; Sign_Mem = 1'b0;
        Branch_Mem = 1'b0; MemToReg_Mem = 1'b0; RegWr_Mem = 1'b0; MemWr_Mem = 1'b0;
        Jal_Mem = 1'b0; Rtype_J_Mem = 1'b0; Rtype_L_Mem = 1'b0; WrByte_Mem = 1'b0;
        LoadByte_Mem = 2'b00;
    endtask

    // Called just after a negedge with inputs applied; checks redirect now, queues WB.
    task automatic step(input string name, input logic [31:0] edata, input logic [4:0] etgt,
                        input logic ewe, input logic epc, input logic [31:0] etarget);
        exp_t e;
        #1;
        total++;
        if (PC_Src !== epc || Flush !== epc || PC_Target !== etarget) begin
            bad++;
            $display("FAIL %s redirect: got src=%0b flush=%0b target=%08h, want src=%0b flush=%0b target=%08h",
                     name, PC_Src, Flush, PC_Target, epc, epc, etarget);
        end
        e.name = name; e.data = edata; e.tgt = etgt; e.we = ewe;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        // Reset clears WB regs even with a live write request
        rst = 1'b1; ALU_ans_Mem = 32'h5; Reg_Target_Mem = 5'd3; RegWr_Mem = 1'b1;
        step("reset", 32'h0, 5'd0, 1'b0, 1'b0, 32'h100);

        clr(); MemWr_Mem = 1'b1; ALU_ans_Mem = 32'h20; busB_Mem = 32'h11223344;
        step("sw_0x20", 32'h20, 5'd0, 1'b0, 1'b0, 32'h100);
        clr(); MemWr_Mem = 1'b1; ALU_ans_Mem = 32'h10; busB_Mem = 32'h8899AABB;
        step("sw_0x10", 32'h10, 5'd0, 1'b0, 1'b0, 32'h100);
        clr(); MemToReg_Mem = 1'b1; RegWr_Mem = 1'b1; ALU_ans_Mem = 32'h10; Reg_Target_Mem = 5'd4;
        step("lw_0x10", 32'h8899AABB, 5'd4, 1'b1, 1'b0, 32'h100);
        clr(); MemWr_Mem = 1'b1; WrByte_Mem = 1'b1; ALU_ans_Mem = 32'h11; busB_Mem = 32'h123456F0;
        step("sb_0x11", 32'h11, 5'd0, 1'b0, 1'b0, 32'h100);
        clr(); MemToReg_Mem = 1'b1; RegWr_Mem = 1'b1; ALU_ans_Mem = 32'h11; Reg_Target_Mem = 5'd5;
        LoadByte_Mem = 2'b01;
        step("lb_0x11", 32'hFFFFFFF0, 5'd5, 1'b1, 1'b0, 32'h100);
        LoadByte_Mem = 2'b10;
        step("lbu_0x11", 32'h000000F0, 5'd5, 1'b1, 1'b0, 32'h100);
        LoadByte_Mem = 2'b11;
        step("lw_mode11", 32'h8899F0BB, 5'd5, 1'b1, 1'b0, 32'h100);
        clr(); MemToReg_Mem = 1'b1; RegWr_Mem = 1'b1; ALU_ans_Mem = 32'h10; Reg_Target_Mem = 5'd6;
        step("lw_merged", 32'h8899F0BB, 5'd6, 1'b1, 1'b0, 32'h100);

        clr(); Branch_Mem = 1'b1; OP_Mem = 6'b000100; ZF_Mem = 1'b1; PC_Addr_Mem = 32'h40;
        ALU_ans_Mem = 32'h7;
        step("beq_taken", 32'h7, 5'd0, 1'b0, 1'b1, 32'h40);
        ZF_Mem = 1'b0;
        step("beq_not", 32'h7, 5'd0, 1'b0, 1'b0, 32'h40);
        OP_Mem = 6'b000101; PC_Addr_Mem = 32'h80;
        step("bne_taken", 32'h7, 5'd0, 1'b0, 1'b1, 32'h80);
        OP_Mem = 6'b000110; Sign_Mem = 1'b1;
        step("blez_taken", 32'h7, 5'd0, 1'b0, 1'b1, 32'h80);
        OP_Mem = 6'b000111;
        step("bgtz_not", 32'h7, 5'd0, 1'b0, 1'b0, 32'h80);
        Sign_Mem = 1'b0;
        step("bgtz_taken", 32'h7, 5'd0, 1'b0, 1'b1, 32'h80);
        OP_Mem = 6'b001000; ZF_Mem = 1'b1;
        step("other_op", 32'h7, 5'd0, 1'b0, 1'b0, 32'h80);
        clr(); Branch_Mem = 1'b1; OP_Mem = 6'b000100; ZF_Mem = 1'b1; PC_Addr_Mem = 32'h40;
        Rtype_J_Mem = 1'b1; ALU_ans_Mem = 32'h300;
        step("jr_over_beq", 32'h300, 5'd0, 1'b0, 1'b1, 32'h300);

        clr(); Jal_Mem = 1'b1; RegWr_Mem = 1'b1; ALU_ans_Mem = 32'h24; Reg_Target_Mem = 5'd5;
        step("jal", 32'h24, 5'd31, 1'b1, 1'b0, 32'h100);
        clr(); OF_Mem = 1'b1; RegWr_Mem = 1'b1; ALU_ans_Mem = 32'h55; Reg_Target_Mem = 5'd6;
        step("alu_ovf", 32'h55, 5'd6, 1'b0, 1'b0, 32'h100);
        clr(); Rtype_L_Mem = 1'b1; Sign_Mem = 1'b1; RegWr_Mem = 1'b1; ALU_ans_Mem = 32'h999;
        Reg_Target_Mem = 5'd7;
        step("slt_true", 32'h1, 5'd7, 1'b1, 1'b0, 32'h100);
        OF_Mem = 1'b1;
        step("slt_ovf", 32'h0, 5'd7, 1'b1, 1'b0, 32'h100);
        clr(); RegWr_Mem = 1'b1; ALU_ans_Mem = 32'h77; Reg_Target_Mem = 5'd0;
        step("r0_write", 32'h77, 5'd0, 1'b0, 1'b0, 32'h100);
        clr(); RegWr_Mem = 1'b1; ALU_ans_Mem = 32'h1234; Reg_Target_Mem = 5'd9;
        step("alu_plain", 32'h1234, 5'd9, 1'b1, 1'b0, 32'h100);

        // Reset during a store and a taken branch: store dropped, no redirect
        clr(); rst = 1'b1; MemWr_Mem = 1'b1; ALU_ans_Mem = 32'h20; busB_Mem = 32'hDEADBEEF;
        RegWr_Mem = 1'b1; Reg_Target_Mem = 5'd8; Branch_Mem = 1'b1; OP_Mem = 6'b000100;
        ZF_Mem = 1'b1; PC_Addr_Mem = 32'h40;
        step("rst_mid_store", 32'h0, 5'd0, 1'b0, 1'b0, 32'h40);
        clr(); MemToReg_Mem = 1'b1; RegWr_Mem = 1'b1; ALU_ans_Mem = 32'h20; Reg_Target_Mem = 5'd8;
        step("lw_after_rst", 32'h11223344, 5'd8, 1'b1, 1'b0, 32'h100);

        clr();
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have these inputs, all 1-bit unless stated: ALU_ans_Mem (32), busB_Mem (32), PC_Addr_Mem (32), OP_Mem (6), Reg_Target_Mem (5), ZF_Mem, OF_Mem, Sign_Mem, Branch_Mem, MemToReg_Mem, RegWr_Mem, MemWr_Mem, Jal_Mem, Rtype_J_Mem, Rtype_L_Mem, WrByte_Mem, LoadByte_Mem (2).
REQ-003 SHALL have these outputs: Wr_Data_Wb output 32, registered write-back data; Reg_Target_Wb output 5, registered destination register; RegWr_Wb output 1, registered write enable; PC_Src output 1, combinational redirect request; PC_Target output 32, combinational redirect address; Flush output 1, combinational IF/ID and ID/EX flush.
REQ-004 SHALL use parameter MEM_WORDS, default 1024, as the data memory depth in 32-bit words, little-endian, byte-addressed.

Function
REQ-005 SHALL form the word index as ALU_ans_Mem[log2(MEM_WORDS)+1:2] and the byte lane as ALU_ans_Mem[1:0]; higher address bits are ignored (wrap-around).
REQ-006 SHALL perform a word store on the rising edge when MemWr_Mem=1, WrByte_Mem=0 and rst=0; address bits [1:0] are ignored.
REQ-007 SHALL perform a byte store of busB_Mem[7:0] into the addressed lane only when MemWr_Mem=1 and WrByte_Mem=1; the other three lanes are unchanged.
REQ-008 SHALL read memory combinationally, so a load in the cycle after a store to the same address returns the new data.
REQ-009 SHALL extract load data per LoadByte_Mem: 00 returns the full word; 01 returns the addressed byte sign-extended; 10 returns it zero-extended; 11 is treated as 00.
REQ-010 SHALL select write-back data by priority:
- Jal_Mem: ALU_ans_Mem, the link value computed in EX.
- MemToReg_Mem: load data.
- Rtype_L_Mem: {31'b0, Sign_Mem^OF_Mem}.
- Otherwise: ALU_ans_Mem.
REQ-011 SHALL force Reg_Target_Wb to 5'd31 when Jal_Mem=1; otherwise Reg_Target_Wb gets Reg_Target_Mem.
REQ-012 SHALL suppress the write (RegWr_Wb<=0) when OF_Mem=1 and Jal_Mem, MemToReg_Mem and Rtype_L_Mem are all 0.
REQ-013 SHALL force RegWr_Wb<=0 whenever the effective target is register 0.
REQ-014 SHALL register Wr_Data_Wb, Reg_Target_Wb and RegWr_Wb every rising edge, giving one-cycle latency from the MEM-stage inputs.
REQ-015 SHALL evaluate the branch condition when Branch_Mem=1, by OP_Mem:
- 000100 (beq): taken if ZF_Mem.
- 000101 (bne): taken if !ZF_Mem.
- 000110 (blez): taken if ZF_Mem|Sign_Mem.
- 000111 (bgtz): taken if !ZF_Mem&!Sign_Mem.
- Any other OP: not taken.
REQ-016 SHALL drive PC_Src=1 and PC_Target=PC_Addr_Mem for a taken branch.
REQ-017 SHALL drive PC_Src=1 and PC_Target=ALU_ans_Mem when Rtype_J_Mem=1 (jr).
REQ-018 SHALL give Rtype_J_Mem precedence if Rtype_J_Mem and a taken branch occur in the same cycle.
REQ-019 SHALL hold PC_Src=0 and PC_Target=PC_Addr_Mem when no redirect is requested.
REQ-020 SHALL drive Flush=PC_Src in the same cycle.
REQ-021 SHALL still complete a store or write-back of the MEM-stage instruction when it causes a redirect, because that instruction is older than the flushed ones.
REQ-022 SHALL gate PC_Src and Flush to 0 while rst=1.

Reset
REQ-023 SHALL set Wr_Data_Wb=0, Reg_Target_Wb=0 and RegWr_Wb=0 on a clock edge with rst=1.
REQ-024 SHALL not clear memory contents on reset, and SHALL block memory writes on an edge with rst=1.
REQ-025 SHALL resume normal one-cycle behaviour on the first edge after rst deasserts; reset asserted mid-store discards that store.

Verification
REQ-026 SHALL verify store then load: store word 0x8899AABB to 0x10, then load word from 0x10 -> Wr_Data_Wb=0x8899AABB one cycle later.
REQ-027 SHALL verify byte load: byte store 0xF0 to 0x11, then lb from 0x11 -> 0xFFFFFFF0; lbu -> 0x000000F0; word at 0x10 -> 0x8899F0BB.
REQ-028 SHALL verify beq: Branch_Mem=1, OP=000100, ZF=1, PC_Addr=0x40 -> PC_Src=1, PC_Target=0x40, Flush=1 that cycle; with ZF=0 -> PC_Src=0.
REQ-029 SHALL verify jal: Jal_Mem=1, ALU_ans=0x24, Reg_Target_Mem=5 -> Reg_Target_Wb=31, Wr_Data_Wb=0x24, RegWr_Wb=1.
REQ-030 SHALL verify overflow and register 0: OF_Mem=1 on an ALU op -> RegWr_Wb=0; an slt with Sign=1, OF=0 -> Wr_Data_Wb=1; Reg_Target_Mem=0 -> RegWr_Wb=0.
REQ-031 SHALL verify reset mid-operation: rst=1 together with MemWr_Mem=1 to 0x20 -> memory at 0x20 unchanged, all WB outputs 0, PC_Src=0.
